sprite_palette_arbiter: RTL and testbench
=========================================

Name: sprite_palette_arbiter

Overview:
- Shares one synchronous sprite index ROM and one combinational 16-entry sprite palette among NUM_SPR sprite layers.
- On each pixel strobe it scans the layers that hit the current pixel in priority order (layer 0 highest) and fetches each layer's colour index.
- It outputs the colour of the first non-transparent index; if there is none, it outputs the background colour.
- Sits between the per-sprite hit/address logic and the VGA colour output register.

Parameters:
- NUM_SPR, 4, number of sprite layers (2..8).
- ADDR_W, 12, shared ROM address width.
- IDX_W, 4, palette index width.
- TRANSP_IDX, 1, palette index treated as transparent (magenta key colour).

Ports:
- Clk  in  1  system clock.
- Reset  in  1  synchronous, active-high reset.
- pix_start  in  1  one-cycle strobe; inputs below are valid in this cycle.
- spr_hit  in  NUM_SPR  per-layer "sprite covers pixel" flags.
- spr_addr  in  NUM_SPR*ADDR_W  per-layer ROM address; layer j occupies bits [j*ADDR_W +: ADDR_W].
- bg_rgb  in  12  background colour {R,G,B} at 4b each.
- rom_addr  out  ADDR_W  address to the shared ROM.
- rom_q  in  IDX_W  ROM data, valid 1 cycle after the address.
- pal_index  out  IDX_W  index to the palette.
- pal_rgb  in  12  palette colour for pal_index, same cycle.
- rgb_out  out  12  resolved pixel colour.
- rgb_valid  out  1  one-cycle pulse when rgb_out updates.
- layer_out  out  4  winning layer, or NUM_SPR when the background wins.
- busy  out  1  high whenever state is not IDLE.
- overrun  out  1  sticky; set when pix_start arrives while busy.

Behaviour:
- Reset values:
  - State is IDLE.
  - pending mask, rgb_out, rgb_valid, layer_out and overrun are all 0.
  - The latched address and background registers are 0.
  - Reset mid-scan aborts the scan immediately and emits no rgb_valid.
- States: IDLE, SEL, CHECK. busy = (state != IDLE).
- IDLE:
  - On pix_start, latch spr_hit into pending, and latch spr_addr and bg_rgb.
  - Go to SEL.
  - Otherwise stay in IDLE.
- SEL:
  - If pending == 0: rgb_out <= latched bg, layer_out <= NUM_SPR, rgb_valid pulses the next cycle, go to IDLE.
  - Else: let j = lowest set bit of pending. Drive rom_addr = addr[j], clear bit j, cur <= j, go to CHECK.
- CHECK:
  - rom_q is valid in this cycle; pal_index = rom_q.
  - If rom_q != TRANSP_IDX: rgb_out <= pal_rgb, layer_out <= cur, rgb_valid pulses the next cycle, go to IDLE.
  - Else go to SEL and continue the scan.
- Idle values: rom_addr = 0 outside SEL; pal_index = 0 outside CHECK.
- Latency, with pix_start in cycle t:
  - No hits: rgb_valid in cycle t+2.
  - Layer 0 opaque: rgb_valid in cycle t+3.
  - Worst case (all layers hit, all transparent): rgb_valid in cycle t+2*NUM_SPR+2, i.e. t+10 for the default NUM_SPR.
- Output hold: rgb_out and layer_out hold their values between rgb_valid pulses. rgb_valid is high for exactly 1 cycle per accepted pix_start.
- pix_start while busy:
  - It is ignored and the inputs are not re-latched.
  - overrun <= 1 and stays set until Reset.
  - This includes pix_start in the final CHECK or SEL cycle.
  - pix_start in the cycle rgb_valid is high (state IDLE) is accepted normally.
- Input changes: changes to spr_hit, spr_addr or bg_rgb after pix_start have no effect on the current scan.
- Layer skipping: layers with hit = 0 cost no cycles; the priority encoder skips them within a single SEL cycle.
- Index values: IDX_W indices are passed to the palette unmodified. Only index == TRANSP_IDX is transparent. Index 0 (black) is opaque.

Test Plan:
- Reset, then pix_start with spr_hit=0000 and bg_rgb=12'h123 -> rgb_valid at t+2, rgb_out=12'h123, layer_out=4, rom_addr stays 0.
- spr_hit=0001, addr0=12'h040, rom_q=5, palette idx5=12'hFD9 -> rom_addr=12'h040 at t+1, pal_index=5 at t+2, rgb_valid at t+3 with rgb_out=12'hFD9 and layer_out=0.
- spr_hit=1111, layers 0/1/2 return rom_q=1 (transparent), layer 3 returns idx3=12'hBBC -> rom_addr sequence addr0, addr1, addr2, addr3 in cycles t+1, t+3, t+5, t+7; rgb_valid at t+9 with rgb_out=12'hBBC and layer_out=3.
- spr_hit=1111, all rom_q=1, bg=12'h000 -> rgb_valid at t+10, layer_out=4; then spr_hit=1010 with layer 1 opaque idx4=12'h611 -> only layer 1 fetched, rgb_out=12'h611, layer_out=1.
- pix_start again at t+4 during a 4-layer scan -> it is ignored, overrun=1, and the original scan completes unchanged. pix_start in the same cycle as rgb_valid is accepted, and overrun stays 1.
- Assert Reset at t+5 mid-scan -> the next cycle has state IDLE, busy=0, rgb_valid=0, rgb_out=0 and overrun=0. A following pix_start runs normally.

Source files
------------

// File: rtl/sprite_palette_arbiter.sv
// Sprite palette arbiter: on each pixel strobe, walks the hitting sprite layers in
// priority order (layer 0 first) through one shared index ROM and one shared palette,
// and resolves the pixel to the first opaque colour, or to the background colour.
module sprite_palette_arbiter #(
  parameter int unsigned NUM_SPR    = 4,
  parameter int unsigned ADDR_W     = 12,
  parameter int unsigned IDX_W      = 4,
  parameter int unsigned TRANSP_IDX = 1
) (
  input  logic                        Clk,
  input  logic                        Reset,
  input  logic                        pix_start,
  input  logic [NUM_SPR-1:0]          spr_hit,
  input  logic [NUM_SPR*ADDR_W-1:0]   spr_addr,
  input  logic [11:0]                 bg_rgb,
  output logic [ADDR_W-1:0]           rom_addr,
  input  logic [IDX_W-1:0]            rom_q,
  output logic [IDX_W-1:0]            pal_index,
  input  logic [11:0]                 pal_rgb,
  output logic [11:0]                 rgb_out,
  output logic                        rgb_valid,
  output logic [3:0]                  layer_out,
  output logic                        busy,
  output logic                        overrun
);

  localparam logic [IDX_W-1:0] LP_TRANSP = IDX_W'(TRANSP_IDX);
  localparam logic [3:0]       LP_BG_LAYER = 4'(NUM_SPR);

  typedef enum logic [1:0] {
    StIdle,
    StSel,
    StCheck
  } state_t;

  state_t                      r_state;
  logic [NUM_SPR-1:0]          r_pending;
  logic [NUM_SPR*ADDR_W-1:0]   r_addr;
  logic [11:0]                 r_bg;
  logic [3:0]                  r_cur;
  logic [11:0]                 r_rgb;
  logic                        r_valid;
  logic [3:0]                  r_layer;
  logic                        r_overrun;

  logic [3:0]                  w_sel_idx;
  logic [ADDR_W-1:0]           w_sel_addr;
  logic [NUM_SPR-1:0]          w_sel_onehot;
  logic                        w_opaque;

  // Priority encoder: lowest pending layer wins; empty layers cost no cycles.
  always_comb begin
    w_sel_idx  = '0;
    w_sel_addr = '0;
    for (int j = NUM_SPR - 1; j >= 0; j--) begin
      if (r_pending[j]) begin
        w_sel_idx  = 4'(j);
        w_sel_addr = r_addr[j*ADDR_W +: ADDR_W];
      end
    end
  end

  // Isolate the lowest set bit so it can be cleared in the same SEL cycle.
  assign w_sel_onehot = r_pending & (~r_pending + {{(NUM_SPR-1){1'b0}}, 1'b1});

  // Index 0 is a real colour; only the key index is see-through.
  assign w_opaque = (rom_q != LP_TRANSP);

  // Shared-resource drives are parked at zero when not in use.
  always_comb begin
    rom_addr  = '0;
    pal_index = '0;
    if (r_state == StSel && r_pending != '0) begin
      rom_addr = w_sel_addr;
    end
    if (r_state == StCheck) begin
      pal_index = rom_q;
    end
  end

  // Scan FSM with registered result, valid pulse and sticky overrun flag.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state   <= StIdle;
      r_pending <= '0;
      r_addr    <= '0;
      r_bg      <= '0;
      r_cur     <= '0;
      r_rgb     <= '0;
      r_valid   <= 1'b0;
      r_layer   <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      // A strobe while scanning is dropped, not queued.
      if (pix_start && r_state != StIdle) begin
        r_overrun <= 1'b1;
      end
      unique case (r_state)
        StIdle: begin
          if (pix_start) begin
            r_pending <= spr_hit;
            r_addr    <= spr_addr;
            r_bg      <= bg_rgb;
            r_state   <= StSel;
          end
        end
        StSel: begin
          if (r_pending == '0) begin
            r_rgb   <= r_bg;
            r_layer <= LP_BG_LAYER;
            r_valid <= 1'b1;
            r_state <= StIdle;
          end else begin
            r_pending <= r_pending & ~w_sel_onehot;
            r_cur     <= w_sel_idx;
            r_state   <= StCheck;
          end
        end
        StCheck: begin
          if (w_opaque) begin
            r_rgb   <= pal_rgb;
            r_layer <= r_cur;
            r_valid <= 1'b1;
            r_state <= StIdle;
          end else begin
            r_state <= StSel;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign rgb_out   = r_rgb;
  assign rgb_valid = r_valid;
  assign layer_out = r_layer;
  assign busy      = (r_state != StIdle);
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_sprite_palette_arbiter.sv
// Bench for sprite_palette_arbiter: behavioural ROM/palette, reference scan model and
// a scoreboard of expected {colour, layer, arrival cycle} per accepted pixel strobe.
module tb_sprite_palette_arbiter;

  localparam int NS = 4;
  localparam int AW = 12;
  localparam int IW = 4;

  logic              Clk = 1'b0;
  logic              Reset;
  logic              pix_start;
  logic [NS-1:0]     spr_hit;
  logic [NS*AW-1:0]  spr_addr;
  logic [11:0]       bg_rgb;
  logic [AW-1:0]     rom_addr;
  logic [IW-1:0]     rom_q;
  logic [IW-1:0]     pal_index;
  logic [11:0]       pal_rgb;
  logic [11:0]       rgb_out;
  logic              rgb_valid;
  logic [3:0]        layer_out;
  logic              busy;
  logic              overrun;

  sprite_palette_arbiter #(
    .NUM_SPR   (NS),
    .ADDR_W    (AW),
    .IDX_W     (IW),
    .TRANSP_IDX(1)
  ) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .pix_start(pix_start),
    .spr_hit  (spr_hit),
    .spr_addr (spr_addr),
    .bg_rgb   (bg_rgb),
    .rom_addr (rom_addr),
    .rom_q    (rom_q),
    .pal_index(pal_index),
    .pal_rgb  (pal_rgb),
    .rgb_out  (rgb_out),
    .rgb_valid(rgb_valid),
    .layer_out(layer_out),
    .busy     (busy),
    .overrun  (overrun)
  );

  always #5 Clk = ~Clk;

  logic [IW-1:0] rom_mem [0:4095];
  logic [11:0]   pal_mem [0:15];

  // Synchronous index ROM and combinational palette.
  always @(posedge Clk) rom_q <= rom_mem[rom_addr];
  assign pal_rgb = pal_mem[pal_index];

  int unsigned cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  typedef struct {
    logic [11:0] rgb;
    logic [3:0]  layer;
    int unsigned due;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: first opaque layer in priority order, two cycles per fetched layer.
  function automatic exp_t model(input logic [NS-1:0] hit, input logic [NS*AW-1:0] addr,
                                 input logic [11:0] bg, input int unsigned t);
    exp_t        e;
    int unsigned lat;
    logic [IW-1:0] idx;
    bit          found;
    lat     = 1;
    found   = 0;
    e.rgb   = bg;
    e.layer = 4'(NS);
    for (int j = 0; j < NS; j++) begin
      if (hit[j] && !found) begin
        lat += 2;
        idx = rom_mem[addr[j*AW +: AW]];
        if (idx != 4'd1) begin
          found   = 1;
          e.rgb   = pal_mem[idx];
          e.layer = 4'(j);
        end
      end
    end
    e.due = t + lat + (found ? 0 : 1);
    return e;
  endfunction

  function automatic logic [NS*AW-1:0] pk(input logic [11:0] a0, input logic [11:0] a1,
                                          input logic [11:0] a2, input logic [11:0] a3);
    return {a3, a2, a1, a0};
  endfunction

  // Result monitor: every valid pulse must match the oldest expectation, on time.
  always @(negedge Clk) begin
    if (rgb_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check_val("spurious_valid", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check_val("rgb_out", 32'(rgb_out), 32'(mon_e.rgb));
        check_val("layer_out", 32'(layer_out), 32'(mon_e.layer));
        check_val("latency_cycle", cyc, mon_e.due);
      end
    end
  end

  // Called at a negedge; returns at the negedge of cycle t+1 with inputs scrambled.
  task automatic do_pixel(input logic [NS-1:0] hit, input logic [NS*AW-1:0] addr,
                          input logic [11:0] bg);
    spr_hit   = hit;
    spr_addr  = addr;
    bg_rgb    = bg;
    pix_start = 1'b1;
    sb.push_back(model(hit, addr, bg, cyc));
    @(negedge Clk);
    pix_start = 1'b0;
    spr_hit   = '1;
    spr_addr  = (NS*AW)'({$urandom, $urandom});
    bg_rgb    = 12'($urandom);
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 40; i++) begin
      if (sb.size() == 0 && busy === 1'b0) break;
      @(negedge Clk);
    end
    check_val(tag, 32'(sb.size()), 32'd0);
    sb.delete();
    @(negedge Clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    Reset     = 1'b1;
    pix_start = 1'b0;
    spr_hit   = '0;
    spr_addr  = '0;
    bg_rgb    = '0;
    for (int i = 0; i < 4096; i++) rom_mem[i] = IW'($urandom_range(0, 15));
    for (int i = 0; i < 16; i++) pal_mem[i] = 12'($urandom);
    rom_mem[12'h040] = 4'd5;  pal_mem[5] = 12'hFD9;
    rom_mem[12'h100] = 4'd1;  rom_mem[12'h101] = 4'd1;  rom_mem[12'h102] = 4'd1;
    rom_mem[12'h103] = 4'd3;  pal_mem[3] = 12'hBBC;
    rom_mem[12'h110] = 4'd1;
    rom_mem[12'h200] = 4'd4;  pal_mem[4] = 12'h611;
    rom_mem[12'h300] = 4'd7;
    rom_mem[12'h050] = 4'd0;  pal_mem[0] = 12'h000;
    rom_mem[12'h0F0] = 4'd9;

    repeat (3) @(negedge Clk);
    check_val("rst_rgb_valid", 32'(rgb_valid), 32'd0);
    check_val("rst_rgb_out", 32'(rgb_out), 32'd0);
    check_val("rst_layer_out", 32'(layer_out), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_overrun", 32'(overrun), 32'd0);
    check_val("rst_rom_addr", 32'(rom_addr), 32'd0);
    check_val("rst_pal_index", 32'(pal_index), 32'd0);
    Reset = 1'b0;
    @(negedge Clk);

    // No hits: background after two cycles, ROM untouched.
    do_pixel(4'b0000, pk(12'h040, 12'h100, 12'h101, 12'h102), 12'h123);
    check_val("nohit_rom_addr", 32'(rom_addr), 32'd0);
    check_val("nohit_busy", 32'(busy), 32'd1);
    wait_done("nohit_done");

    // Single opaque layer 0.
    do_pixel(4'b0001, pk(12'h040, 12'h100, 12'h101, 12'h102), 12'h321);
    check_val("l0_rom_addr", 32'(rom_addr), 32'h040);
    @(negedge Clk);
    check_val("l0_pal_index", 32'(pal_index), 32'd5);
    check_val("l0_rom_addr_idle", 32'(rom_addr), 32'd0);
    wait_done("l0_done");

    // Three transparent layers then opaque layer 3; addresses every other cycle.
    do_pixel(4'b1111, pk(12'h100, 12'h101, 12'h102, 12'h103), 12'h0AA);
    for (int k = 0; k < 4; k++) begin
      check_val($sformatf("seq_rom_addr%0d", k), 32'(rom_addr), 32'(12'h100 + k));
      if (k < 3) begin
        @(negedge Clk);
        check_val($sformatf("seq_pal_index%0d", k), 32'(pal_index), 32'd1);
        @(negedge Clk);
      end
    end
    wait_done("seq_done");

    // Worst case: all transparent, then sparse hits skip absent layers.
    do_pixel(4'b1111, pk(12'h100, 12'h101, 12'h102, 12'h110), 12'h000);
    wait_done("worst_done");
    do_pixel(4'b1010, pk(12'h0F0, 12'h200, 12'h0F0, 12'h300), 12'h555);
    check_val("skip_rom_addr", 32'(rom_addr), 32'h200);
    wait_done("skip_done");

    // Index 0 is opaque black.
    do_pixel(4'b0100, pk(12'h100, 12'h101, 12'h050, 12'h103), 12'hFFF);
    wait_done("black_done");
    check_val("no_overrun_yet", 32'(overrun), 32'd0);

    // Strobe mid-scan is dropped; strobe on the valid cycle is accepted.
    do_pixel(4'b1111, pk(12'h100, 12'h101, 12'h102, 12'h103), 12'h0AA);
    repeat (3) @(negedge Clk);
    pix_start = 1'b1;
    spr_hit   = 4'b0000;
    bg_rgb    = 12'hFFF;
    @(negedge Clk);
    pix_start = 1'b0;
    check_val("overrun_set", 32'(overrun), 32'd1);
    for (int i = 0; i < 20; i++) begin
      if (rgb_valid === 1'b1) break;
      @(negedge Clk);
    end
    check_val("valid_seen", 32'(rgb_valid), 32'd1);
    do_pixel(4'b0001, pk(12'h040, 12'h100, 12'h101, 12'h102), 12'h000);
    wait_done("b2b_done");
    check_val("overrun_sticky", 32'(overrun), 32'd1);

    // Reset mid-scan aborts without a result.
    do_pixel(4'b1111, pk(12'h100, 12'h101, 12'h102, 12'h110), 12'h000);
    repeat (4) @(negedge Clk);
    sb.delete();
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    check_val("abort_busy", 32'(busy), 32'd0);
    check_val("abort_rgb_valid", 32'(rgb_valid), 32'd0);
    check_val("abort_rgb_out", 32'(rgb_out), 32'd0);
    check_val("abort_overrun", 32'(overrun), 32'd0);
    check_val("abort_layer_out", 32'(layer_out), 32'd0);
    @(negedge Clk);
    do_pixel(4'b0001, pk(12'h040, 12'h100, 12'h101, 12'h102), 12'h777);
    wait_done("post_rst_done");

    // Random pixels against the reference model.
    for (int n = 0; n < 24; n++) begin
      do_pixel(NS'($urandom), (NS*AW)'({$urandom, $urandom}), 12'($urandom));
      wait_done($sformatf("rand_done%0d", n));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
